// File: rtl/pipo_arb_pkg.sv
// Shared types and defaults for the PIPO load arbiter and its round-robin picker.
// Also provides the one-hot helper used to build the grant vector.
package pipo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_NREQ        = 4;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int MAX_NREQ        = 16;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
// Reusable by any arbiter that keeps its own rotating priority pointer.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            any_req
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      // Wrap at NREQ rather than at 2^PW so non-power-of-two counts rotate correctly.
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared PIPO register,
// then holds it stable for HOLD_CYCLES cycles before arbitrating again.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NREQ        = DEF_NREQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int PW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      q,
  output logic [PW-1:0]         q_owner,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic             any_req;
  logic             load;
  logic [WIDTH-1:0] win_data;
  logic [PW-1:0]    ptr_nxt;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .any_req (any_req)
  );

  assign win_data = data[int'(win)*WIDTH +: WIDTH];
  assign ptr_nxt  = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = (state == IDLE) && any_req;
    busy = (state == HOLD);
  end

  // Requests are ignored in HOLD; only the counter moves until arbitration resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
      grant   <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      grant <= '0;
      if (load) begin
        q       <= win_data;
        q_owner <= win;
        q_valid <= 1'b1;
        grant   <= NREQ'(onehot(32'(win)));
        ptr     <= ptr_nxt;
        cnt     <= CW'(HOLD_CYCLES-1);
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule
